// File: rtl/apb_req_bridge_if.sv
// ----------------------------------------------------------------------------
// apb_req_bridge_if
//   Bundles the request/grant port and the APB3 master port of
//   apb_req_bridge into one interface.
//
//   Request side (requester -> bridge): req_i, we_i, addr_i, wdata_i
//   Request side (bridge -> requester): gnt_o, rvalid_o, rdata_o, err_o
//   APB side (bridge -> completer):     psel_o, penable_o, pwrite_o,
//                                       paddr_o, pwdata_o
//   APB side (completer -> bridge):     prdata_i, pready_i, pslverr_i
//
//   Modports:
//     slave  - used by the bridge; it serves requests and drives APB.
//     master - used by the environment, which issues requests and acts as
//              the APB completer.
//   Signal suffixes are given from the bridge's point of view.
// ----------------------------------------------------------------------------
interface apb_req_bridge_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);

  logic                      req_i;
  logic                      gnt_o;
  logic                      we_i;
  logic [APB_ADDR_WIDTH-1:0] addr_i;
  logic [APB_DATA_WIDTH-1:0] wdata_i;
  logic                      rvalid_o;
  logic [APB_DATA_WIDTH-1:0] rdata_o;
  logic                      err_o;

  logic                      psel_o;
  logic                      penable_o;
  logic                      pwrite_o;
  logic [APB_ADDR_WIDTH-1:0] paddr_o;
  logic [APB_DATA_WIDTH-1:0] pwdata_o;
  logic [APB_DATA_WIDTH-1:0] prdata_i;
  logic                      pready_i;
  logic                      pslverr_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    input  prdata_i, pready_i, pslverr_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    output prdata_i, pready_i, pslverr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

endinterface

// File: rtl/apb_req_bridge.sv
// ----------------------------------------------------------------------------
// apb_req_bridge
//   Single-outstanding request/grant to APB3 master bridge. A core-style
//   req/gnt/rvalid transaction is turned into one APB SETUP + ACCESS
//   sequence; read data and slave error come back as a one-cycle rvalid
//   pulse registered one cycle after the APB transfer completes.
//
// Ports
//   clk_i  - clock, all logic on the rising edge
//   rst_i  - asynchronous, active-high reset
//   bus    - apb_req_bridge_if.slave: request port (req/gnt/we/addr/wdata,
//            rvalid/rdata/err) and APB master port (psel/penable/pwrite/
//            paddr/pwdata, prdata/pready/pslverr)
//
// Parameters
//   APB_ADDR_WIDTH, APB_DATA_WIDTH - bus widths (must match the interface)
//   TIMEOUT_CYCLES - longest ACCESS phase before a forced error response
//   ERR_RDATA      - rdata returned on a forced (timeout) error response
//
// Configuration
//   APB_TIMEOUT_EN - when defined, a watchdog ends an ACCESS phase that has
//                    lasted TIMEOUT_CYCLES cycles without pready and answers
//                    with err=1, rdata=ERR_RDATA. When undefined, ACCESS
//                    waits for pready indefinitely and the two timeout
//                    parameters are unused.
// ----------------------------------------------------------------------------
module apb_req_bridge #(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA      = APB_DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  apb_req_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      gnt;

`ifdef APB_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             expire;

  // The counter value after this ACCESS cycle; expiry fires in the ACCESS
  // cycle that brings the count up to TIMEOUT_CYCLES, so a hung transfer
  // spends exactly TIMEOUT_CYCLES cycles in ACCESS. Saturating add keeps
  // the count from ever wrapping.
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    expire  = (state_q == ST_ACCESS) && !bus.pready_i && (cnt_inc == CNT_MAX);
    cnt_d   = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !bus.pready_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (^ERR_RDATA) ^ TIMEOUT_CYCLES[0];
`endif

  // Next-state and datapath. The request payload is captured only at grant
  // and then held, so paddr/pwrite/pwdata stay put through SETUP, ACCESS
  // and the following IDLE. prdata/pslverr are looked at only in the
  // completing ACCESS cycle.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt = bus.req_i;
        if (bus.req_i) begin
          paddr_d  = bus.addr_i;
          pwrite_d = bus.we_i;
          pwdata_d = bus.wdata_i;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.pready_i) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          err_d    = bus.pslverr_i;
          rdata_d  = pwrite_q ? '0 : bus.prdata_i;
        end
`ifdef APB_TIMEOUT_EN
        else if (expire) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = ERR_RDATA;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // psel/penable decode straight from the state flops, so an asynchronous
  // reset drops them in the same cycle.
  assign bus.gnt_o     = gnt;
  assign bus.psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign bus.penable_o = (state_q == ST_ACCESS);
  assign bus.pwrite_o  = pwrite_q;
  assign bus.paddr_o   = paddr_q;
  assign bus.pwdata_o  = pwdata_q;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.err_o     = err_q;

`ifndef SYNTHESIS
  a_penable_needs_psel : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.penable_o |-> bus.psel_o);

  a_gnt_only_idle : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.gnt_o |-> (state_q == ST_IDLE));

  a_setup_to_access : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.psel_o && !bus.penable_o) |=> (bus.psel_o && bus.penable_o));

  a_rvalid_single : assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_q |=> !rvalid_q);

  a_payload_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.penable_o |-> ($stable(paddr_q) && $stable(pwrite_q) && $stable(pwdata_q)));
`endif

endmodule

// File: tb/tb_apb_req_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_req_bridge
//   Self-checking bench for apb_req_bridge. The environment acts as both the
//   requester and a simple APB completer whose wait states, read data and
//   slave error come from a per-transaction descriptor. Expected responses
//   come from a transaction-level model (latency, rdata, err) built from the
//   bridge's documented rules. Timeout checks run when APB_TIMEOUT_EN is
//   defined (TIMEOUT_CYCLES = 8).
// ----------------------------------------------------------------------------
module tb_apb_req_bridge;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          TMO     = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEADBEEF;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        serr;
    int          waits;
  } txn_t;

  typedef struct {
    bit          granted;
    bit          done;
    int          gcyc;
    int          rcyc;
    logic [31:0] rdata;
    logic        err;
    bit          setup_ok;
    bit          stable;
    bit          gnt_clean;
    int          access_n;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  apb_req_bridge_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

  apb_req_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (ERR_VAL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level expectation: gnt->rvalid is 3 cycles plus one per
  // wait state; a watchdog answer arrives after TMO ACCESS cycles.
  function automatic void model(input txn_t t, output int lat,
                                output logic [31:0] rd, output logic er);
`ifdef APB_TIMEOUT_EN
    if (t.waits >= TMO) begin
      lat = 2 + TMO;
      rd  = ERR_VAL;
      er  = 1'b1;
      return;
    end
`endif
    lat = 3 + t.waits;
    rd  = t.we ? 32'h0 : t.prdata;
    er  = t.serr;
  endfunction

  function automatic txn_t rand_txn(input int max_waits);
    txn_t t;
    t.we     = 1'($urandom);
    t.addr   = $urandom;
    t.wdata  = $urandom;
    t.prdata = $urandom;
    t.serr   = 1'($urandom);
    t.waits  = $urandom_range(0, max_waits);
    return t;
  endfunction

  // Drives one transaction and records what was seen; entered and left at
  // one time unit after a rising edge. Returns in the rvalid cycle so a
  // following call can be granted in that same cycle.
  task automatic do_txn(input txn_t t, input bit hold_req, output obs_t o);
    o = '{default: 0};
    o.setup_ok  = 1'b1;
    o.stable    = 1'b1;
    o.gnt_clean = 1'b1;
    bus.req_i   = 1'b1;
    bus.we_i    = t.we;
    bus.addr_i  = t.addr;
    bus.wdata_i = t.wdata;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.gnt_o === 1'b1) begin
        o.granted = 1'b1;
        o.gcyc    = cyc;
      end
      next_cycle();
      if (o.granted) break;
    end
    bus.req_i = hold_req;
    if (!o.granted) return;
    bus.we_i    = 1'($urandom);
    bus.addr_i  = $urandom;
    bus.wdata_i = $urandom;
    for (int k = 0; k < 40; k++) begin
      if (bus.rvalid_o === 1'b1) begin
        o.done  = 1'b1;
        o.rcyc  = cyc;
        o.rdata = bus.rdata_o;
        o.err   = bus.err_o;
        break;
      end
      if (k == 0 && !(bus.psel_o === 1'b1 && bus.penable_o === 1'b0)) o.setup_ok = 1'b0;
      if (bus.psel_o === 1'b1) begin
        if (bus.paddr_o !== t.addr || bus.pwrite_o !== t.we || bus.pwdata_o !== t.wdata)
          o.stable = 1'b0;
      end
      if (bus.psel_o === 1'b1 && bus.penable_o === 1'b1) begin
        bus.pready_i  = (o.access_n >= t.waits);
        bus.prdata_i  = bus.pready_i ? t.prdata : $urandom;
        bus.pslverr_i = bus.pready_i ? t.serr : 1'($urandom);
        o.access_n++;
      end else begin
        bus.pready_i  = 1'($urandom);
        bus.prdata_i  = $urandom;
        bus.pslverr_i = 1'($urandom);
      end
      #1;
      if (bus.gnt_o === 1'b1 && bus.psel_o === 1'b1) o.gnt_clean = 1'b0;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (bus.psel_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_psel got=%b exp=0", bus.psel_o); end
    checks++; if (bus.penable_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_penable got=%b exp=0", bus.penable_o); end
    checks++; if (bus.rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid got=%b exp=0", bus.rvalid_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.err_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
    checks++; if (bus.paddr_o !== 32'h0 || bus.pwdata_o !== 32'h0 || bus.pwrite_o !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_payload got=%h/%h/%b exp=0/0/0", bus.paddr_o, bus.pwdata_o, bus.pwrite_o);
    end
    bus.req_i = 1'b1;
    #1;
    checks++; if (bus.gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_gnt_follows_req got=%b exp=1", bus.gnt_o); end
    bus.req_i = 1'b0;
    #1;
    checks++; if (bus.gnt_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_gnt_low got=%b exp=0", bus.gnt_o); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    checks++; if (bus.psel_o !== 1'b0 || bus.rvalid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_release_idle got psel=%b rvalid=%b exp 0/0", bus.psel_o, bus.rvalid_o);
    end
  endtask

  task automatic test_read();
    txn_t t;
    obs_t o;
    t = '{we: 1'b0, addr: 32'h1A10_0004, wdata: $urandom, prdata: 32'h1234_5678, serr: 1'b0, waits: 0};
    do_txn(t, 1'b0, o);
    checks++; if (!(o.granted && o.done)) begin failures++; $display("[TB] FAIL t1_complete got gnt=%0d rvalid=%0d exp 1/1", o.granted, o.done); end
    checks++; if (o.rcyc - o.gcyc !== 3) begin failures++; $display("[TB] FAIL t1_latency got=%0d exp=3", o.rcyc - o.gcyc); end
    checks++; if (o.rdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL t1_rdata got=%h exp=12345678", o.rdata); end
    checks++; if (o.err !== 1'b0) begin failures++; $display("[TB] FAIL t1_err got=%b exp=0", o.err); end
    checks++; if (!(o.setup_ok && o.stable)) begin failures++; $display("[TB] FAIL t1_apb_phases got setup=%0d stable=%0d exp 1/1", o.setup_ok, o.stable); end
    next_cycle();
    checks++; if (bus.rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL t1_rvalid_pulse got=%b exp=0", bus.rvalid_o); end
    next_cycle();
    checks++; if (bus.rdata_o !== 32'h1234_5678 || bus.err_o !== 1'b0) begin
      failures++; $display("[TB] FAIL t1_hold got=%h/%b exp=12345678/0", bus.rdata_o, bus.err_o);
    end
    checks++; if (bus.paddr_o !== 32'h1A10_0004) begin failures++; $display("[TB] FAIL t1_paddr_hold got=%h exp=1a100004", bus.paddr_o); end
  endtask

  task automatic test_write_wait();
    txn_t t;
    obs_t o;
    t = '{we: 1'b1, addr: $urandom, wdata: 32'hCAFE_F00D, prdata: 32'hFFFF_0000 | $urandom, serr: 1'b0, waits: 4};
    do_txn(t, 1'b0, o);
    checks++; if (!o.done) begin failures++; $display("[TB] FAIL t2_complete got=0 exp=1"); end
    checks++; if (o.access_n !== 5) begin failures++; $display("[TB] FAIL t2_access_cycles got=%0d exp=5", o.access_n); end
    checks++; if (!o.stable) begin failures++; $display("[TB] FAIL t2_pwdata_stable got=0 exp=1"); end
    checks++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin failures++; $display("[TB] FAIL t2_resp got=%h/%b exp=0/0", o.rdata, o.err); end
    checks++; if (o.rcyc - o.gcyc !== 7) begin failures++; $display("[TB] FAIL t2_latency got=%0d exp=7", o.rcyc - o.gcyc); end
    next_cycle();
  endtask

  task automatic test_slverr();
    txn_t t1, t2;
    obs_t o1, o2;
    t1 = '{we: 1'b0, addr: $urandom, wdata: $urandom, prdata: $urandom, serr: 1'b1, waits: 1};
    t2 = '{we: 1'b0, addr: $urandom, wdata: $urandom, prdata: $urandom, serr: 1'b0, waits: 0};
    do_txn(t1, 1'b1, o1);
    do_txn(t2, 1'b0, o2);
    checks++; if (o1.err !== 1'b1 || o1.rdata !== t1.prdata) begin
      failures++; $display("[TB] FAIL t3_slverr got=%h/%b exp=%h/1", o1.rdata, o1.err, t1.prdata);
    end
    checks++; if (!o2.granted || o2.gcyc !== o1.rcyc) begin
      failures++; $display("[TB] FAIL t3_regrant got cycle=%0d exp=%0d", o2.gcyc, o1.rcyc);
    end
    checks++; if (o2.err !== 1'b0 || o2.rdata !== t2.prdata || !o2.stable) begin
      failures++; $display("[TB] FAIL t3_second got=%h/%b stable=%0d exp=%h/0/1", o2.rdata, o2.err, o2.stable, t2.prdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    txn_t t;
    obs_t o;
    int   lat;
    logic [31:0] rd;
    logic er;
    int   prev_g;
    int   prev_r;
    for (int i = 0; i < 4; i++) begin
      t = rand_txn(0);
      do_txn(t, (i < 3), o);
      model(t, lat, rd, er);
      checks++; if (!o.done || o.rdata !== rd || o.err !== er) begin
        failures++; $display("[TB] FAIL t4_resp%0d got=%h/%b exp=%h/%b", i, o.rdata, o.err, rd, er);
      end
      checks++; if (!(o.gnt_clean && o.setup_ok && o.stable)) begin
        failures++; $display("[TB] FAIL t4_phases%0d got clean=%0d setup=%0d stable=%0d exp 1/1/1", i, o.gnt_clean, o.setup_ok, o.stable);
      end
      if (i > 0) begin
        checks++; if (o.gcyc - prev_g !== 3 || o.gcyc !== prev_r) begin
          failures++; $display("[TB] FAIL t4_gnt_spacing%0d got=%0d exp=3", i, o.gcyc - prev_g);
        end
      end
      prev_g = o.gcyc;
      prev_r = o.rcyc;
    end
    next_cycle();
  endtask

  task automatic test_reset_in_access();
    txn_t t;
    obs_t o;
    bit   got;
    bit   seen;
    got  = 1'b0;
    seen = 1'b0;
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b0;
    bus.addr_i  = $urandom;
    bus.wdata_i = $urandom;
    bus.pready_i = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      got = (bus.gnt_o === 1'b1);
      next_cycle();
    end
    bus.req_i = 1'b0;
    checks++; if (!got) begin failures++; $display("[TB] FAIL t5_grant got=0 exp=1"); end
    next_cycle();
    checks++; if (bus.penable_o !== 1'b1) begin failures++; $display("[TB] FAIL t5_in_access got=%b exp=1", bus.penable_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0) begin
      failures++; $display("[TB] FAIL t5_async_drop got=%b/%b exp=0/0", bus.psel_o, bus.penable_o);
    end
    next_cycle();
    rst = 1'b0;
    bus.pready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.rvalid_o === 1'b1 || bus.psel_o === 1'b1) seen = 1'b1;
      next_cycle();
    end
    checks++; if (seen) begin failures++; $display("[TB] FAIL t5_no_response got=1 exp=0"); end
    t = '{we: 1'b0, addr: 32'h1A10_0004, wdata: $urandom, prdata: 32'h1234_5678, serr: 1'b0, waits: 0};
    do_txn(t, 1'b0, o);
    checks++; if (o.rcyc - o.gcyc !== 3 || o.rdata !== 32'h1234_5678 || o.err !== 1'b0) begin
      failures++; $display("[TB] FAIL t5_after_reset got lat=%0d rdata=%h err=%b exp 3/12345678/0", o.rcyc - o.gcyc, o.rdata, o.err);
    end
    next_cycle();
  endtask

  task automatic test_random();
    txn_t t;
    obs_t o;
    int   lat;
    logic [31:0] rd;
    logic er;
    bit   hold;
    for (int i = 0; i < 24; i++) begin
`ifdef APB_TIMEOUT_EN
      t = rand_txn(10);
`else
      t = rand_txn(5);
`endif
      hold = (i < 23) && ($urandom_range(0, 1) == 1);
      do_txn(t, hold, o);
      model(t, lat, rd, er);
      checks++; if (!o.done || o.rcyc - o.gcyc !== lat || o.rdata !== rd || o.err !== er) begin
        failures++; $display("[TB] FAIL rnd%0d got lat=%0d rdata=%h err=%b exp %0d/%h/%b", i, o.rcyc - o.gcyc, o.rdata, o.err, lat, rd, er);
      end
      checks++; if (!(o.stable && o.setup_ok && o.gnt_clean)) begin
        failures++; $display("[TB] FAIL rnd_phases%0d got stable=%0d setup=%0d clean=%0d exp 1/1/1", i, o.stable, o.setup_ok, o.gnt_clean);
      end
      if (!hold) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) next_cycle();
      end
    end
    next_cycle();
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    txn_t t;
    obs_t o;
    t = '{we: 1'b1, addr: $urandom, wdata: $urandom, prdata: $urandom, serr: 1'b0, waits: 30};
    do_txn(t, 1'b0, o);
    checks++; if (!o.done || o.access_n !== TMO || o.rdata !== ERR_VAL || o.err !== 1'b1) begin
      failures++; $display("[TB] FAIL t6_expire got n=%0d rdata=%h err=%b exp %0d/%h/1", o.access_n, o.rdata, o.err, TMO, ERR_VAL);
    end
    next_cycle();
    t = '{we: 1'b0, addr: $urandom, wdata: $urandom, prdata: $urandom, serr: 1'b0, waits: TMO - 1};
    do_txn(t, 1'b0, o);
    checks++; if (!o.done || o.access_n !== TMO || o.rdata !== t.prdata || o.err !== 1'b0) begin
      failures++; $display("[TB] FAIL t6_ready_wins got n=%0d rdata=%h err=%b exp %0d/%h/0", o.access_n, o.rdata, o.err, TMO, t.prdata);
    end
    next_cycle();
  endtask
`endif

  initial begin
    bus.req_i     = 1'b0;
    bus.we_i      = 1'b0;
    bus.addr_i    = '0;
    bus.wdata_i   = '0;
    bus.prdata_i  = '0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    #1;
    test_reset();
    test_read();
    test_write_wait();
    test_slverr();
    test_back_to_back();
    test_reset_in_access();
    test_random();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=hung exp=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
